// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: streams TAPS pixels through one shared, externally
// instanced 8x8 registered multiplier and accumulates the weighted sum.
// Weights live locally. Pixels arrive on a valid/ready stream, and the
// result leaves on a valid/ready output.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high. Valid, once raised by a producer,
// holds its data stable until that transfer takes place.
module conv_mac_sequencer #(
  parameter int TAPS    = 9,
  parameter int ACC_W   = 20,
  parameter int MUL_LAT = 2,
  localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_wr_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [7:0]       w_data,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_data,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_product,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [AW:0]   TAPS_W   = (AW + 1)'(TAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  state_e             state_q;
  logic [7:0]         w_q [TAPS];
  logic [AW-1:0]      tap_q;
  logic [ACC_W-1:0]   acc_q;
  logic [MUL_LAT-1:0] vp_q;
  logic [7:0]         mul_a_q;
  logic [7:0]         mul_b_q;
  logic               pix_ready_q;
  logic               busy_q;
  logic               res_valid_q;
  logic [ACC_W-1:0]   res_data_q;

  logic accept;
  logic in_idle;
  logic w_write;

  assign in_idle = (state_q == ST_IDLE);
  assign accept  = (state_q == ST_RUN) && pix_valid && pix_ready_q;
  assign w_write = in_idle && w_wr_en && ({1'b0, w_addr} < TAPS_W);

  assign pix_ready   = pix_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign dbg_state_o = state_q;

  // Kernel weight store. It is only writable while idle, so a run always
  // sees a consistent kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
    end else if (w_write) begin
      w_q[w_addr] <= w_data;
    end
  end

  // Valid pipe that tracks the multiplier latency. Its MSB marks the cycle
  // in which mul_product belongs to an accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_q <= '0;
    end else begin
      vp_q <= (vp_q << 1) | MUL_LAT'(accept);
    end
  end

  // Accumulator. Start clears it, and each returning product is added
  // modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (in_idle && start) begin
      acc_q <= '0;
    end else if (vp_q[MUL_LAT-1]) begin
      acc_q <= acc_q + ACC_W'(mul_product);
    end
  end

  // Control FSM with registered stream, operand and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RUN;
            tap_q       <= '0;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            mul_a_q <= pix_data;
            mul_b_q <= w_q[tap_q];
            tap_q   <= tap_q + 1'b1;
            if (tap_q == LAST_TAP) begin
              state_q     <= ST_DRAIN;
              pix_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (vp_q == '0) begin
            state_q     <= ST_DONE;
            res_data_q  <= acc_q;
            res_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Testbench for conv_mac_sequencer. It models the external registered
// multiplier and checks every dot product against a plain sum-of-products
// model.
module tb_conv_mac_sequencer;

  localparam int TAPS    = 9;
  localparam int ACC_W   = 20;
  localparam int MUL_LAT = 2;
  localparam int AW      = $clog2(TAPS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic             w_wr_en = 1'b0;
  logic [AW-1:0]    w_addr = '0;
  logic [7:0]       w_data = '0;
  logic             start = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [7:0]       pix_data = '0;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_product = '0;
  logic             busy;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [ACC_W-1:0] res_data;
  logic [1:0]       dbg_state;

  conv_mac_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .dbg_state_o(dbg_state)
  );

  // External multiplier: one register stage on the product.
  always @(posedge clk) mul_product <= 16'(mul_a) * 16'(mul_b);

  // ---------------- reference model / scoreboard ----------------
  int w_m [TAPS];
  int pix_v [TAPS];
  logic [ACC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [ACC_W-1:0] model_dot();
    longint sum = 0;
    for (int i = 0; i < TAPS; i++) sum += longint'(w_m[i]) * longint'(pix_v[i]);
    return ACC_W'(sum);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_weight(input int a, input int d);
    @(negedge clk);
    w_wr_en = 1'b1;
    w_addr  = AW'(a);
    w_data  = 8'(d);
    if (a < TAPS) w_m[a] = d;
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  task automatic load_all(input int mode);
    for (int i = 0; i < TAPS; i++) begin
      case (mode)
        0: write_weight(i, 1);
        1: write_weight(i, 255);
        2: write_weight(i, i);
        default: write_weight(i, $urandom_range(0, 255));
      endcase
    end
  endtask

  // gap: 0 unbroken, 1 valid every other cycle, 2 random bubbles.
  // hold: cycles to keep res_ready low in DONE, with a start pulse inside.
  task automatic run_dot(input int gap, input int rr_pct, input int hold,
                         input bit wr_run, input bit wr_start);
    logic [ACC_W-1:0] exp_v;
    logic [ACC_W-1:0] held;
    int i, slot, budget, hcnt, start_cyc;
    bit done, got;
    @(negedge clk);
    start = 1'b1;
    if (wr_start) begin
      w_wr_en = 1'b1; w_addr = '0; w_data = 8'd7; w_m[0] = 7;
    end
    exp_q.push_back(model_dot());
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    w_wr_en = 1'b0;
    i = 0; slot = 0; budget = 500;
    while (i < TAPS && budget > 0) begin
      case (gap)
        0: pix_valid = 1'b1;
        1: pix_valid = slot[0];
        default: pix_valid = ($urandom_range(0, 2) != 0);
      endcase
      pix_data = pix_valid ? 8'(pix_v[i]) : 8'($urandom_range(0, 255));
      if (wr_run && slot == 0) begin
        w_wr_en = 1'b1; w_addr = '0; w_data = 8'd7;
      end else begin
        w_wr_en = 1'b0;
      end
      if (pix_valid && pix_ready) i++;
      slot++; budget--;
      @(negedge clk);
    end
    w_wr_en = 1'b0;
    if (budget == 0) check_val("stream_timeout", 0, 1);
    check_val("drain_ready", 32'(pix_ready), 0);
    check_val("drain_busy", 32'(busy), 1);
    pix_valid = 1'b1;
    pix_data  = 8'($urandom_range(1, 255));
    got = 0; done = 0; budget = 200; hcnt = 0; held = '0;
    while (!done && budget > 0) begin
      if (res_valid) begin
        if (!got) begin
          got = 1;
          if (gap == 0) check_val("latency", 32'(cyc - start_cyc), 32'(TAPS + MUL_LAT + 1));
          exp_v = exp_q.pop_front();
          check_val("res_data", 32'(res_data), 32'(exp_v));
          held = res_data;
        end else begin
          check_val("res_hold", 32'(res_data), 32'(held));
        end
        if (hold > 0 && hcnt < hold) begin
          res_ready = 1'b0;
          start = (hcnt == 2);
          hcnt++;
        end else begin
          start = 1'b0;
          res_ready = ($urandom_range(0, 99) < rr_pct);
        end
        if (res_ready) done = 1;
      end else begin
        res_ready = ($urandom_range(0, 99) < rr_pct);
      end
      @(negedge clk);
      budget--;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    if (!done) check_val("result_timeout", 0, 1);
    check_val("post_valid", 32'(res_valid), 0);
    check_val("post_busy", 32'(busy), 0);
    check_val("post_state", 32'(dbg_state), 0);
    if (hold > 0) begin
      @(negedge clk);
      @(negedge clk);
      check_val("start_ignored_busy", 32'(busy), 0);
      check_val("start_ignored_ready", 32'(pix_ready), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < TAPS; i++) w_m[i] = 0;
    repeat (3) @(negedge clk);
    pix_valid = 1'b1;
    check_val("rst_ready", 32'(pix_ready), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_valid", 32'(res_valid), 0);
    check_val("rst_data", 32'(res_data), 0);
    check_val("rst_mul_a", 32'(mul_a), 0);
    check_val("rst_mul_b", 32'(mul_b), 0);
    check_val("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_no_ready", 32'(pix_ready), 0);
    pix_valid = 1'b0;

    // Weights 1, pixels 1..9, unbroken.
    load_all(0);
    for (int i = 0; i < TAPS; i++) pix_v[i] = i + 1;
    run_dot(0, 100, 0, 0, 0);

    // All 255: largest sum, no wrap.
    load_all(1);
    for (int i = 0; i < TAPS; i++) pix_v[i] = 255;
    run_dot(0, 100, 0, 0, 0);

    // Weights 0..8, pixels 9..1, alternating bubbles; out-of-range write ignored.
    load_all(2);
    write_weight(12, 200);
    for (int i = 0; i < TAPS; i++) pix_v[i] = TAPS - i;
    run_dot(1, 100, 0, 0, 0);

    // Back-pressure in DONE with an ignored start pulse.
    run_dot(0, 100, 5, 0, 0);

    // Weight write during RUN ignored; same-cycle start+write in IDLE lands.
    load_all(0);
    for (int i = 0; i < TAPS; i++) pix_v[i] = i + 1;
    run_dot(0, 100, 0, 1, 0);
    run_dot(0, 100, 0, 0, 1);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pix_valid = 1'b1;
      pix_data = 8'(k + 1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_ready", 32'(pix_ready), 0);
    check_val("arst_busy", 32'(busy), 0);
    check_val("arst_valid", 32'(res_valid), 0);
    check_val("arst_data", 32'(res_data), 0);
    check_val("arst_mul_a", 32'(mul_a), 0);
    check_val("arst_mul_b", 32'(mul_b), 0);
    check_val("arst_state", 32'(dbg_state), 0);
    pix_valid = 1'b0;
    for (int i = 0; i < TAPS; i++) w_m[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_dot(0, 100, 0, 0, 0);
    load_all(0);
    run_dot(0, 100, 0, 0, 0);

    // Randomized runs with bubbles and result back-pressure.
    for (int r = 0; r < 8; r++) begin
      load_all(3);
      for (int i = 0; i < TAPS; i++) pix_v[i] = $urandom_range(0, 255);
      run_dot(2, 50, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
